sti_pixel_rx: RTL and testbench

Serial receiver that sits directly downstream of the serial transmitter. It consumes the so_data/so_valid bit stream, assembles MSB-first bytes, and writes each byte to the 256-entry pixel memory at sequential addresses. After the end-of-transfer indication it fills all unwritten addresses with a constant byte, then asserts pixel_finish.

---
 rtl/sti_pkg.sv | 17 +
 rtl/sti_rx_shifter.sv | 37 +++
 rtl/sti_pixel_rx.sv | 167 ++++++++++++++++
 tb/tb_sti_pixel_rx.sv | 283 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/sti_pkg.sv
// Shared types and constants for the STI pixel receiver.
// Holds the receiver state encoding, the byte width and the default fill value.
package sti_pkg;

    localparam int BYTE_W = 8;

    localparam logic [BYTE_W-1:0] FILL_BYTE_DEFAULT = 8'h00;

    typedef enum logic [2:0] {
        IDLE,
        SHIFT,
        FLUSH,
        FILL,
        DONE
    } rx_state_t;

endpackage

// File: rtl/sti_rx_shifter.sv
// Serial-to-parallel shifter for the STI pixel receiver.
// Collects bits MSB-first, flags the eighth bit of a byte and offers the
// partially received bits left-aligned for a frame that ends early.
module sti_rx_shifter
    import sti_pkg::*;
(
    input  logic              clk,
    input  logic              reset,
    input  logic              shift_en,
    input  logic              bit_in,
    input  logic              clear,
    output logic [2:0]        bitcnt,
    output logic              byte_done,
    output logic [BYTE_W-1:0] byte_val,
    output logic [BYTE_W-1:0] partial
);

    logic [BYTE_W-1:0] shreg;

    // Shift one bit per accepted cycle; clear drops the partial count after a flush
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            shreg  <= '0;
            bitcnt <= '0;
        end else if (clear) begin
            bitcnt <= '0;
        end else if (shift_en) begin
            shreg  <= {shreg[BYTE_W-2:0], bit_in};
            bitcnt <= bitcnt + 3'd1;
        end
    end

    assign byte_done = shift_en && (bitcnt == 3'd7);
    assign byte_val  = {shreg[BYTE_W-2:0], bit_in};
    assign partial   = shreg << (4'd8 - {1'b0, bitcnt});

endmodule

// File: rtl/sti_pixel_rx.sv
// STI pixel receiver: assembles serial bytes, writes them to sequential pixel
// addresses, fills the remaining addresses after the end-of-transfer indication
// and then reports completion.
// Optional feature macro: STI_RX_CHECKSUM_EN adds an XOR checksum of data writes.
module sti_pixel_rx
    import sti_pkg::*;
#(
    parameter int                ADDR_W    = 8,
    parameter logic [BYTE_W-1:0] FILL_BYTE = FILL_BYTE_DEFAULT
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              so_data,
    input  logic              so_valid,
    input  logic              pi_end,
    output logic              pixel_wr,
    output logic [ADDR_W-1:0] pixel_addr,
    output logic [BYTE_W-1:0] pixel_dataout,
    output logic              pixel_finish,
    output logic              frame_err,
    output logic              ovf
`ifdef STI_RX_CHECKSUM_EN
    ,
    output logic [BYTE_W-1:0] checksum
`endif
);

    localparam logic [ADDR_W-1:0] WPTR_MAX = '1;
    localparam logic [ADDR_W-1:0] WPTR_ONE = 1;

    rx_state_t         state;
    rx_state_t         next_state;
    logic [ADDR_W-1:0] wptr;
    logic              full;
    logic              end_pend;
    logic              data_wr_q;
    logic [ADDR_W-1:0] data_addr_q;
    logic [BYTE_W-1:0] data_q;

    logic              shift_en;
    logic              in_fill;
    logic              in_flush;
    logic              flush_wr;
    logic [2:0]        bitcnt;
    logic              byte_done;
    logic [BYTE_W-1:0] byte_val;
    logic [BYTE_W-1:0] partial;

    assign in_fill  = (state == FILL);
    assign in_flush = (state == FLUSH);
    assign flush_wr = in_flush && !full;
    assign shift_en = so_valid && ((state == IDLE) || (state == SHIFT));

    sti_rx_shifter u_shifter (
        .clk       (clk),
        .reset     (reset),
        .shift_en  (shift_en),
        .bit_in    (so_data),
        .clear     (in_flush),
        .bitcnt    (bitcnt),
        .byte_done (byte_done),
        .byte_val  (byte_val),
        .partial   (partial)
    );

    // State register
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    // Next state: frames always win over the pending end request, and the fill
    // only starts once the shifter is empty and the last byte write has gone out
    always_comb begin
        next_state = state;
        case (state)
            IDLE: begin
                if (so_valid) begin
                    next_state = SHIFT;
                end else if (end_pend && !data_wr_q && (bitcnt == 3'd0)) begin
                    next_state = full ? DONE : FILL;
                end
            end
            SHIFT: begin
                if (!so_valid) begin
                    next_state = (bitcnt == 3'd0) ? IDLE : FLUSH;
                end
            end
            FLUSH:   next_state = IDLE;
            FILL: begin
                if (wptr == WPTR_MAX) begin
                    next_state = DONE;
                end
            end
            DONE:    next_state = DONE;
            default: next_state = IDLE;
        endcase
    end

    // Write pointer, completed-byte write register and sticky status flags
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wptr        <= '0;
            full        <= 1'b0;
            end_pend    <= 1'b0;
            data_wr_q   <= 1'b0;
            data_addr_q <= '0;
            data_q      <= '0;
            frame_err   <= 1'b0;
            ovf         <= 1'b0;
        end else begin
            data_wr_q <= 1'b0;
            if (pi_end) begin
                end_pend <= 1'b1;
            end
            if (byte_done) begin
                if (full) begin
                    ovf <= 1'b1;
                end else begin
                    data_wr_q   <= 1'b1;
                    data_addr_q <= wptr;
                    data_q      <= byte_val;
                    wptr        <= wptr + WPTR_ONE;
                    if (wptr == WPTR_MAX) begin
                        full <= 1'b1;
                    end
                end
            end
            if (in_flush) begin
                frame_err <= 1'b1;
                if (full) begin
                    ovf <= 1'b1;
                end else begin
                    wptr <= wptr + WPTR_ONE;
                    if (wptr == WPTR_MAX) begin
                        full <= 1'b1;
                    end
                end
            end
            if (in_fill) begin
                wptr <= wptr + WPTR_ONE;
            end
        end
    end

    assign pixel_wr      = data_wr_q | in_fill | flush_wr;
    assign pixel_addr    = (in_fill || in_flush) ? wptr : data_addr_q;
    assign pixel_dataout = in_fill ? FILL_BYTE : (in_flush ? partial : data_q);
    assign pixel_finish  = (state == DONE);

`ifdef STI_RX_CHECKSUM_EN
    // Running XOR over received data bytes; fill writes are excluded
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            checksum <= '0;
        end else if (data_wr_q) begin
            checksum <= checksum ^ data_q;
        end else if (flush_wr) begin
            checksum <= checksum ^ partial;
        end
    end
`endif

endmodule

// File: tb/tb_sti_pixel_rx.sv
// Testbench for sti_pixel_rx: drives serial frames, predicts every memory write
// from a byte-level model and checks each DUT write against it.
module tb_sti_pixel_rx;

    logic       clk = 1'b0;
    logic       reset;
    logic       so_data;
    logic       so_valid;
    logic       pi_end;
    logic       pixel_wr;
    logic [7:0] pixel_addr;
    logic [7:0] pixel_dataout;
    logic       pixel_finish;
    logic       frame_err;
    logic       ovf;
`ifdef STI_RX_CHECKSUM_EN
    logic [7:0] checksum;
`endif

    int checks = 0;
    int errors = 0;
    int cyc    = 0;

    logic [15:0] exp_q[$];
    logic [15:0] wr_log[$];
    int          wr_cyc[$];
    int          bit_cyc[$];

    int m_wptr;
    bit m_full;
    bit m_ovf;
    bit m_err;
    int m_acc;
    int m_nbits;

    sti_pixel_rx dut (
        .clk           (clk),
        .reset         (reset),
        .so_data       (so_data),
        .so_valid      (so_valid),
        .pi_end        (pi_end),
        .pixel_wr      (pixel_wr),
        .pixel_addr    (pixel_addr),
        .pixel_dataout (pixel_dataout),
        .pixel_finish  (pixel_finish),
        .frame_err     (frame_err),
        .ovf           (ovf)
`ifdef STI_RX_CHECKSUM_EN
        ,
        .checksum      (checksum)
`endif
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Every DUT write must match the next write the model predicted
    always @(negedge clk) begin
        logic [15:0] e;
        if (!reset && pixel_wr) begin
            wr_log.push_back({pixel_addr, pixel_dataout});
            wr_cyc.push_back(cyc);
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("[TB] FAIL unexpected_write: got addr 0x%0h data 0x%0h, expected no write",
                         pixel_addr, pixel_dataout);
            end else begin
                e = exp_q.pop_front();
                if ({pixel_addr, pixel_dataout} !== e) begin
                    errors++;
                    $display("[TB] FAIL write: got addr 0x%0h data 0x%0h, expected addr 0x%0h data 0x%0h",
                             pixel_addr, pixel_dataout, e[15:8], e[7:0]);
                end
            end
        end
    end

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", name, actual, expected);
        end
    endtask

    task automatic modelByte(input logic [7:0] b);
        if (m_full) begin
            m_ovf = 1'b1;
        end else begin
            exp_q.push_back({m_wptr[7:0], b});
            m_wptr++;
            if (m_wptr == 256) begin
                m_full = 1'b1;
                m_wptr = 0;
            end
        end
    endtask

    task automatic clearModel();
        exp_q.delete();
        wr_log.delete();
        wr_cyc.delete();
        bit_cyc.delete();
        m_wptr  = 0;
        m_full  = 1'b0;
        m_ovf   = 1'b0;
        m_err   = 1'b0;
        m_acc   = 0;
        m_nbits = 0;
    endtask

    task automatic doReset();
        reset    = 1'b1;
        so_valid = 1'b0;
        so_data  = 1'b0;
        pi_end   = 1'b0;
        clearModel();
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;
    endtask

    // Drive n bits of v MSB-first, one per cycle, and feed the model
    task automatic applyStimulus(input logic [31:0] v, input int n);
        for (int i = n - 1; i >= 0; i--) begin
            @(posedge clk);
            #1;
            so_valid = 1'b1;
            so_data  = v[i];
            bit_cyc.push_back(cyc);
            m_acc = ((m_acc << 1) | int'(v[i])) & 8'hFF;
            m_nbits++;
            if (m_nbits == 8) begin
                modelByte(m_acc[7:0]);
                m_acc   = 0;
                m_nbits = 0;
            end
        end
    endtask

    task automatic endFrame();
        logic [7:0] part;
        @(posedge clk);
        #1;
        so_valid = 1'b0;
        so_data  = 1'b0;
        if (m_nbits != 0) begin
            part  = 8'(m_acc << (8 - m_nbits));
            m_err = 1'b1;
            modelByte(part);
            m_acc   = 0;
            m_nbits = 0;
        end
    endtask

    task automatic endTransfer();
        pi_end = 1'b1;
        if (!m_full) begin
            for (int a = m_wptr; a < 256; a++) exp_q.push_back({8'(a), 8'h00});
        end
    endtask

    task automatic waitFinish(input int budget);
        int n = 0;
        while (!pixel_finish && n < budget) begin
            @(negedge clk);
            n++;
        end
        #1;
        checkOutput("finish_reached", pixel_finish, 1);
    endtask

    task automatic settle(input int n);
        repeat (n) @(negedge clk);
        #1;
    endtask

    task automatic checkFlags(input string tag);
        checkOutput({tag, "_frame_err"}, frame_err, m_err);
        checkOutput({tag, "_ovf"}, ovf, m_ovf);
        checkOutput({tag, "_drained"}, exp_q.size(), 0);
    endtask

    initial begin
        int  n;
        bit  found;

        // 16-bit frame then end of transfer, followed by a full fill
        doReset();
        settle(1);
        checkOutput("reset_outputs", {pixel_wr, pixel_addr, pixel_dataout, pixel_finish, frame_err, ovf}, 0);
        applyStimulus(32'hA53C, 16);
        endFrame();
        endTransfer();
        waitFinish(400);
        checkFlags("t1");
        checkOutput("t1_byte0", wr_log[0], 16'h00A5);
        checkOutput("t1_byte1", wr_log[1], 16'h013C);
        checkOutput("t1_lat0", wr_cyc[0], bit_cyc[7] + 1);
        checkOutput("t1_lat1", wr_cyc[1], bit_cyc[15] + 1);
        checkOutput("t1_fill_first", wr_log[2], 16'h0200);
        checkOutput("t1_writes", wr_log.size(), 256);

        // Two back-to-back bytes with a single idle cycle between them
        doReset();
        applyStimulus(32'h81, 8);
        endFrame();
        applyStimulus(32'h7E, 8);
        endFrame();
        settle(4);
        checkFlags("t2");
        checkOutput("t2_byte0", wr_log[0], 16'h0081);
        checkOutput("t2_byte1", wr_log[1], 16'h017E);
        checkOutput("t2_writes", wr_log.size(), 2);

        // Short frame is flushed left-aligned and flagged
        doReset();
        applyStimulus(32'h16, 5);
        endFrame();
        settle(4);
        checkOutput("t3_partial", wr_log[0], 16'h00B0);
        checkOutput("t3_err_now", frame_err, 1);
        endTransfer();
        waitFinish(400);
        checkFlags("t3");
        checkOutput("t3_writes", wr_log.size(), 256);

        // End request mid-frame must not cut the frame short
        doReset();
        applyStimulus(32'h12, 8);
        pi_end = 1'b1;
        applyStimulus(32'h3456, 16);
        endFrame();
        endTransfer();
        waitFinish(400);
        checkFlags("t4");
        checkOutput("t4_byte2", wr_log[2], 16'h0256);
        checkOutput("t4_fill_start", wr_log[3], 16'h0300);

        // 257 bytes in one frame: memory fills, last byte overflows, no fill
        doReset();
        for (int i = 0; i < 257; i++) applyStimulus(32'(i[7:0] ^ 8'h5A), 8);
        endFrame();
        settle(3);
        endTransfer();
        waitFinish(50);
        checkFlags("t5");
        checkOutput("t5_ovf", ovf, 1);
        checkOutput("t5_writes", wr_log.size(), 256);
        checkOutput("t5_last", wr_log[255], 16'hFFA5);

        // Reset in the middle of the fill, then a fresh frame
        doReset();
        endTransfer();
        n     = 0;
        found = 1'b0;
        while (!found && n < 400) begin
            @(negedge clk);
            #2;
            if (pixel_wr && pixel_addr == 8'h40) found = 1'b1;
            n++;
        end
        checkOutput("t6_reached_40", found, 1);
        reset = 1'b1;
        pi_end = 1'b0;
        #1;
        checkOutput("t6_reset_outputs", {pixel_wr, pixel_addr, pixel_dataout, pixel_finish, frame_err, ovf}, 0);
        clearModel();
        @(posedge clk);
        #1 reset = 1'b0;
        applyStimulus(32'hFF, 8);
        endFrame();
        settle(4);
        checkFlags("t6");
        checkOutput("t6_byte0", wr_log[0], 16'h00FF);
        checkOutput("t6_finish_low", pixel_finish, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
